serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/full_adder.sv | 20 ++
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg : shared types and constants for the bit-serial subtractor
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_sub_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder : single-bit full adder cell
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor : LSB-first bit-serial a - b using one full adder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              ovf_q, ovf_d;
  logic              fa_s, fa_c;

  // b is stored inverted, so the adder with carry-in 1 forms a + ~b + 1.
  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        diff_d  = {fa_s, diff_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          borrow_d = ~fa_c;
          ovf_d    = carry_q ^ fa_c;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign overflow  = ovf_q;
  assign zero      = (diff_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor : directed self-checking bench for serial_subtractor
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow;
  logic       overflow;
  logic       zero;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, check latency, then check the result flags.
  task automatic op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                    input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    chk({tag, "_in_ready"}, in_ready, 1);
    a = av; b = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, in_ready, 0);
    repeat (7) tick();
    chk({tag, "_early"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_borrow"}, borrow, eb);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_zero"}, zero, ez);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, in_ready, 1);
    chk({tag, "_novalid"}, out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 1);
    reset = 1'b0;
    tick();

    op("s05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    release_result("s05_03");
    op("s03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    release_result("s03_05");
    op("s80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    release_result("s80_01");
    op("s7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    release_result("s7F_FF");

    // Result must hold while the consumer stalls.
    op("s2A_2A", 8'h2A, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b1);
    a = 8'hFF; b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_diff", diff, 8'h00);
      chk("stall_zero", zero, 1);
      chk("stall_borrow", borrow, 0);
    end
    release_result("s2A_2A");

    // Asynchronous reset in the 4th RUN cycle discards the operation.
    a = 8'h55; b = 8'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_run_busy", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_diff", diff, 0);
    chk("arst_zero", zero, 1);
    tick();
    reset = 1'b0;
    tick();
    op("s10_01", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
    release_result("s10_01");

    // in_valid held high: only IDLE may consume an operand pair.
    a = 8'h09; b = 8'h04; in_valid = 1'b1;
    tick();
    chk("b2b_accept", in_ready, 0);
    a = 8'h01; b = 8'h01;
    repeat (8) tick();
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_diff1", diff, 8'h05);
    repeat (2) tick();
    chk("b2b_hold", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle", in_ready, 1);
    tick();
    chk("b2b_accept2", in_ready, 0);
    in_valid = 1'b0;
    repeat (8) tick();
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_diff2", diff, 8'h00);
    chk("b2b_zero2", zero, 1);
    release_result("b2b2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
